// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// The default word-index width is derived from the RAM depth so the two cannot drift apart.
package mem_pkg;

   localparam int          RAM_WORDS          = 4096;
   localparam int          DEFAULT_RAM_ADDR_W = $clog2(RAM_WORDS);
   localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RESP,
      ERR
   } arb_state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } port_t;

   // Round-robin helper: the port that did not win last time.
   function automatic port_t other_port(input port_t p);
      return (p == PORT_I) ? PORT_D : PORT_I;
   endfunction

endpackage

// File: rtl/addr_decode.sv
// Checks that a CPU byte address is word aligned and inside the RAM window,
// and extracts the RAM word index from it.
module addr_decode
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          RAM_ADDR_W = DEFAULT_RAM_ADDR_W
) (
   input  logic [31:0]           addr,
   output logic                  valid,
   output logic [RAM_ADDR_W-1:0] index
);

   logic aligned;
   logic in_window;

   assign aligned   = (addr[1:0] == 2'b00);
   assign in_window = (addr[31:RAM_ADDR_W+2] == BASE_ADDR[31:RAM_ADDR_W+2]);
   assign valid     = aligned && in_window;
   assign index     = addr[RAM_ADDR_W+1:2];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, 1-cycle-read-latency RAM between the CPU instruction
// and data ports, with round-robin arbitration and registered outputs.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          RAM_ADDR_W = DEFAULT_RAM_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  i_req,
   input  logic [31:0]           i_addr,
   output logic                  i_ack,
   output logic [31:0]           i_rdata,
   output logic                  i_err,

   input  logic                  d_req,
   input  logic [31:0]           d_addr,
   input  logic                  d_write,
   input  logic [31:0]           d_wdata,
   output logic                  d_ack,
   output logic [31:0]           d_rdata,
   output logic                  d_err,

   output logic [RAM_ADDR_W-1:0] ram_address,
   output logic                  ram_read,
   output logic                  ram_write,
   output logic [31:0]           ram_writedata,
   input  logic [31:0]           ram_readdata
);

   arb_state_t            state;
   port_t                 winner;
   port_t                 last;
   logic                  d_is_write;

   logic                  i_valid;
   logic                  d_valid;
   logic [RAM_ADDR_W-1:0] i_index;
   logic [RAM_ADDR_W-1:0] d_index;

   logic                  i_pending;
   logic                  d_pending;
   port_t                 grant;

   addr_decode #(
      .BASE_ADDR  (BASE_ADDR),
      .RAM_ADDR_W (RAM_ADDR_W)
   ) u_i_decode (
      .addr  (i_addr),
      .valid (i_valid),
      .index (i_index)
   );

   addr_decode #(
      .BASE_ADDR  (BASE_ADDR),
      .RAM_ADDR_W (RAM_ADDR_W)
   ) u_d_decode (
      .addr  (d_addr),
      .valid (d_valid),
      .index (d_index)
   );

   // A port whose ack is high this cycle is still holding the old request, so it is masked.
   always_comb begin
      i_pending = i_req && !i_ack;
      d_pending = d_req && !d_ack;
      grant     = PORT_I;
      if (i_pending && d_pending) begin
         grant = other_port(last);
      end else if (d_pending) begin
         grant = PORT_D;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         winner        <= PORT_I;
         last          <= PORT_D;
         d_is_write    <= 1'b0;
         i_ack         <= 1'b0;
         i_err         <= 1'b0;
         i_rdata       <= '0;
         d_ack         <= 1'b0;
         d_err         <= 1'b0;
         d_rdata       <= '0;
         ram_address   <= '0;
         ram_read      <= 1'b0;
         ram_write     <= 1'b0;
         ram_writedata <= '0;
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;

         case (state)
            IDLE: begin
               if (i_pending || d_pending) begin
                  winner <= grant;
                  last   <= grant;
                  if (grant == PORT_D) begin
                     d_is_write <= d_write;
                     if (d_valid) begin
                        ram_address <= d_index;
                        ram_read    <= !d_write;
                        ram_write   <= d_write;
                        if (d_write) begin
                           ram_writedata <= d_wdata;
                        end
                        state <= CMD;
                     end else begin
                        state <= ERR;
                     end
                  end else begin
                     d_is_write <= 1'b0;
                     if (i_valid) begin
                        ram_address <= i_index;
                        ram_read    <= 1'b1;
                        ram_write   <= 1'b0;
                        state       <= CMD;
                     end else begin
                        state <= ERR;
                     end
                  end
               end
            end

            CMD: begin
               ram_read  <= 1'b0;
               ram_write <= 1'b0;
               state     <= RESP;
            end

            // The RAM sampled the command during CMD, so its read data is valid now.
            RESP: begin
               if (winner == PORT_I) begin
                  i_ack   <= 1'b1;
                  i_rdata <= ram_readdata;
               end else begin
                  d_ack <= 1'b1;
                  if (!d_is_write) begin
                     d_rdata <= ram_readdata;
                  end
               end
               state <= IDLE;
            end

            ERR: begin
               if (winner == PORT_I) begin
                  i_ack <= 1'b1;
                  i_err <= 1'b1;
               end else begin
                  d_ack <= 1'b1;
                  d_err <= 1'b1;
               end
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = '0;
   logic        d_write = 1'b0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [11:0] ram_address;
   logic        ram_read;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata = '0;

   logic [31:0] mem [0:4095];
   int          word4_writes = 0;
   int          ack_overlap = 0;
   int          rw_overlap = 0;
   int          ram_busy = 0;
   logic [11:0] last_rd_addr = '0;

   int          check_count = 0;
   int          pass_count = 0;

   int          lat;
   logic [31:0] rdata;
   logic        err;
   int          busy_before;
   int          stray_acks;
   logic [3:0]  order = '0;
   int          gaps [4];
   int          acks;
   int          cyc;
   int          since;

   mem_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .i_req         (i_req),
      .i_addr        (i_addr),
      .i_ack         (i_ack),
      .i_rdata       (i_rdata),
      .i_err         (i_err),
      .d_req         (d_req),
      .d_addr        (d_addr),
      .d_write       (d_write),
      .d_wdata       (d_wdata),
      .d_ack         (d_ack),
      .d_rdata       (d_rdata),
      .d_err         (d_err),
      .ram_address   (ram_address),
      .ram_read      (ram_read),
      .ram_write     (ram_write),
      .ram_writedata (ram_writedata),
      .ram_readdata  (ram_readdata)
   );

   always #5 clk = ~clk;

   // RAM model: read data appears one cycle after ram_read is sampled.
   always @(posedge clk) begin
      if (ram_write) begin
         mem[ram_address] <= ram_writedata;
         if (ram_address == 12'd4) word4_writes <= word4_writes + 1;
      end
      if (ram_read) ram_readdata <= mem[ram_address];
   end

   always @(negedge clk) begin
      if (i_ack && d_ack) ack_overlap++;
      if (ram_read && ram_write) rw_overlap++;
      if (ram_read || ram_write) ram_busy++;
      if (ram_read) last_rd_addr = ram_address;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Presents one request at a negedge and waits (bounded) for its ack; cycles counts posedges.
   task automatic applyStimulus(input logic use_d, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, output int cycles,
                                output logic [31:0] rd, output logic er);
      logic done;
      done   = 1'b0;
      cycles = 0;
      rd     = '0;
      er     = 1'b0;
      if (use_d) begin
         d_req = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      while (!done && cycles < 20) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (use_d ? d_ack : i_ack) begin
            done = 1'b1;
            rd   = use_d ? d_rdata : i_rdata;
            er   = use_d ? d_err : i_err;
         end
      end
      if (!done) cycles = 99;
      i_req   = 1'b0;
      d_req   = 1'b0;
      d_write = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_flags", 32'({i_ack, d_ack, i_err, d_err, ram_read, ram_write}), 32'd0);
      checkOutput("reset_ram_address", 32'(ram_address), 32'd0);
      checkOutput("reset_i_rdata", i_rdata, 32'd0);
      checkOutput("reset_d_rdata", d_rdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 4096; k++) mem[k] = '0;
      mem[0]    = 32'h2402_0005;
      mem[4095] = 32'hCAFE_F00D;
      @(negedge clk);
      doReset();

      // Instruction fetch of word 0.
      applyStimulus(1'b0, 1'b0, 32'hBFC0_0000, '0, lat, rdata, err);
      checkOutput("t1_latency", 32'(lat), 32'd3);
      checkOutput("t1_i_rdata", rdata, 32'h2402_0005);
      checkOutput("t1_i_err", 32'(err), 32'd0);
      @(negedge clk);
      checkOutput("t1_ack_one_cycle", 32'(i_ack), 32'd0);

      // Data write then read-back of word 4.
      applyStimulus(1'b1, 1'b1, 32'hBFC0_0010, 32'hDEAD_BEEF, lat, rdata, err);
      checkOutput("t2_write_latency", 32'(lat), 32'd3);
      checkOutput("t2_write_err", 32'(err), 32'd0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'hBFC0_0010, '0, lat, rdata, err);
      checkOutput("t2_read_latency", 32'(lat), 32'd3);
      checkOutput("t2_d_rdata", rdata, 32'hDEAD_BEEF);
      checkOutput("t2_word4_writes", 32'(word4_writes), 32'd1);
      @(negedge clk);

      // Both ports request continuously after reset: grants alternate starting with I.
      doReset();
      i_req = 1'b1; i_addr = 32'hBFC0_0000;
      d_req = 1'b1; d_addr = 32'hBFC0_0010; d_write = 1'b0;
      acks = 0; cyc = 0; since = 0;
      while (acks < 4 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         since++;
         @(negedge clk);
         if (i_ack || d_ack) begin
            order[acks] = d_ack;
            gaps[acks]  = since;
            since = 0;
            acks++;
            if (acks == 4) begin
               i_req = 1'b0;
               d_req = 1'b0;
            end
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      checkOutput("t3_ack_count", 32'(acks), 32'd4);
      checkOutput("t3_order_IDID", 32'(order), 32'b1010);
      for (int k = 0; k < 4; k++) checkOutput($sformatf("t3_spacing_%0d", k), 32'(gaps[k]), 32'd3);
      checkOutput("t3_i_rdata", i_rdata, 32'h2402_0005);
      checkOutput("t3_d_rdata", d_rdata, 32'hDEAD_BEEF);
      @(negedge clk);

      // Misaligned and out-of-window data accesses never touch the RAM.
      busy_before = ram_busy;
      applyStimulus(1'b1, 1'b0, 32'hBFC0_0002, '0, lat, rdata, err);
      checkOutput("t4_misaligned_latency", 32'(lat), 32'd2);
      checkOutput("t4_misaligned_err", 32'(err), 32'd1);
      checkOutput("t4_rdata_held", rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h1111_2222, lat, rdata, err);
      checkOutput("t4_window_latency", 32'(lat), 32'd2);
      checkOutput("t4_window_err", 32'(err), 32'd1);
      checkOutput("t4_ram_untouched", 32'(ram_busy - busy_before), 32'd0);
      @(negedge clk);

      // Reset during the CMD cycle of a write aborts the access without an ack.
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'hBFC0_0020; d_wdata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t5_cmd_write", 32'(ram_write), 32'd1);
      rst = 1'b0; d_req = 1'b0; d_write = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t5_flags_zero", 32'({i_ack, d_ack, i_err, d_err, ram_read, ram_write}), 32'd0);
      checkOutput("t5_ram_address_zero", 32'(ram_address), 32'd0);
      checkOutput("t5_ram_writedata_zero", ram_writedata, 32'd0);
      checkOutput("t5_i_rdata_zero", i_rdata, 32'd0);
      checkOutput("t5_d_rdata_zero", d_rdata, 32'd0);
      rst = 1'b1;
      stray_acks = 0;
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
         if (d_ack || i_ack) stray_acks++;
      end
      checkOutput("t5_no_ack", 32'(stray_acks), 32'd0);
      checkOutput("t5_write_kept", mem[8], 32'h1234_5678);
      applyStimulus(1'b0, 1'b0, 32'hBFC0_0000, '0, lat, rdata, err);
      checkOutput("t5_ifetch_latency", 32'(lat), 32'd3);
      checkOutput("t5_ifetch_rdata", rdata, 32'h2402_0005);
      @(negedge clk);

      // Last word of the window, then the first address past it.
      applyStimulus(1'b1, 1'b0, 32'hBFC0_3FFC, '0, lat, rdata, err);
      checkOutput("t6_last_latency", 32'(lat), 32'd3);
      checkOutput("t6_last_rdata", rdata, 32'hCAFE_F00D);
      checkOutput("t6_last_err", 32'(err), 32'd0);
      checkOutput("t6_ram_address", 32'(last_rd_addr), 32'h0000_0FFF);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'hBFC0_4000, '0, lat, rdata, err);
      checkOutput("t6_past_latency", 32'(lat), 32'd2);
      checkOutput("t6_past_err", 32'(err), 32'd1);
      @(negedge clk);

      checkOutput("ack_never_concurrent", 32'(ack_overlap), 32'd0);
      checkOutput("rw_never_concurrent", 32'(rw_overlap), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
